// File: rtl/trapezoid_raster_stream.sv
// Trapezoid scan-converter: loads four vertices of a horizontal-edged
// trapezoid and streams every covered integer pixel over valid/ready.
// Row bounds come from exact numerators divided by dy each row, so the
// edges carry no accumulated rounding drift.
module trapezoid_raster_stream #(
    parameter int unsigned W          = 8,
    parameter int unsigned SERPENTINE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nt,
    input  logic signed [W-1:0] xi,
    input  logic signed [W-1:0] yi,
    input  logic                po_ready,
    output logic                busy,
    output logic                po,
    output logic signed [W-1:0] xo,
    output logic signed [W-1:0] yo,
    output logic                done,
    output logic                err
);

    localparam int unsigned DW   = W + 1;
    localparam int unsigned AW   = 2 * W + 2;
    localparam bit          SERP = (SERPENTINE != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    // Captured vertices
    logic signed [W-1:0]  xul_q, xur_q, xdl_q, xdr_q, yu_q, yd_q;
    logic signed [W-1:0]  xul_d, xur_d, xdl_d, xdr_d, yu_d, yd_d;
    // Edge deltas and exact edge numerators for the next row
    logic signed [DW-1:0] dy_q, dxl_q, dxr_q, dy_d, dxl_d, dxr_d;
    logic signed [AW-1:0] acc_l_q, acc_r_q, acc_l_d, acc_r_d;
    // Current row bounds and scan bookkeeping
    logic signed [W-1:0]  row_l_q, row_r_q, row_l_d, row_r_d;
    logic                 odd_q, odd_d;
    logic                 row_load_q, row_load_d;
    logic [1:0]           load_cnt_q, load_cnt_d;
    // Next values of the registered outputs
    logic                 busy_d, po_d, done_d, err_d;
    logic signed [W-1:0]  xo_d, yo_d;

    // Combinational helpers
    logic signed [DW-1:0] dy_c, dxl_c, dxr_c;
    logic signed [AW-1:0] div_c, xl_c, xr_c;
    logic                 bad_c, row_ok_c, rev_c, eor_c, last_row_c, xfer_c;

    // Floor of n/d for d > 0 (native division truncates toward zero)
    function automatic logic signed [AW-1:0] floor_div(
        input logic signed [AW-1:0] n,
        input logic signed [AW-1:0] d
    );
        logic signed [AW-1:0] q;
        logic signed [AW-1:0] r;
        q = n / d;
        r = n % d;
        if (r < AW'(0)) q = q - AW'(1);
        return q;
    endfunction

    // Ceiling of n/d for d > 0
    function automatic logic signed [AW-1:0] ceil_div(
        input logic signed [AW-1:0] n,
        input logic signed [AW-1:0] d
    );
        logic signed [AW-1:0] q;
        logic signed [AW-1:0] r;
        q = n / d;
        r = n % d;
        if (r > AW'(0)) q = q + AW'(1);
        return q;
    endfunction

    // Setup arithmetic, row-bound division and scan-position decode
    always_comb begin
        dy_c       = DW'(yu_q) - DW'(yd_q);
        dxl_c      = DW'(xul_q) - DW'(xdl_q);
        dxr_c      = DW'(xur_q) - DW'(xdr_q);
        bad_c      = (yd_q > yu_q) || (xdl_q > xdr_q) || (xul_q > xur_q);
        div_c      = (dy_q == DW'(0)) ? AW'(1) : AW'(dy_q);
        xl_c       = ceil_div(acc_l_q, div_c);
        xr_c       = floor_div(acc_r_q, div_c);
        row_ok_c   = (xl_c <= xr_c);
        rev_c      = SERP && odd_q;
        eor_c      = rev_c ? (xo == row_l_q) : (xo == row_r_q);
        last_row_c = (yo == yu_q);
        xfer_c     = po && po_ready;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (nt) state_nx = S_LOAD;
            S_LOAD:  if (load_cnt_q == 2'd2) state_nx = S_SETUP;
            S_SETUP: state_nx = bad_c ? S_DONE : S_RUN;
            S_RUN: begin
                if (!row_load_q) begin
                    if (xfer_c && eor_c && last_row_c) state_nx = S_DONE;
                end else if (!row_ok_c && last_row_c) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM output and datapath next-value logic
    always_comb begin
        xul_d      = xul_q;
        xur_d      = xur_q;
        xdl_d      = xdl_q;
        xdr_d      = xdr_q;
        yu_d       = yu_q;
        yd_d       = yd_q;
        dy_d       = dy_q;
        dxl_d      = dxl_q;
        dxr_d      = dxr_q;
        acc_l_d    = acc_l_q;
        acc_r_d    = acc_r_q;
        row_l_d    = row_l_q;
        row_r_d    = row_r_q;
        odd_d      = odd_q;
        row_load_d = row_load_q;
        load_cnt_d = load_cnt_q;
        busy_d     = busy;
        po_d       = po;
        xo_d       = xo;
        yo_d       = yo;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state)
            S_IDLE: begin
                if (nt) begin
                    xul_d      = xi;
                    yu_d       = yi;
                    busy_d     = 1'b1;
                    load_cnt_d = 2'd0;
                end
            end
            S_LOAD: begin
                load_cnt_d = load_cnt_q + 2'd1;
                case (load_cnt_q)
                    2'd0: xur_d = xi;
                    2'd1: begin
                        xdl_d = xi;
                        yd_d  = yi;
                    end
                    default: xdr_d = xi;
                endcase
            end
            S_SETUP: begin
                dy_d    = dy_c;
                dxl_d   = dxl_c;
                dxr_d   = dxr_c;
                // Numerators for row 1; row 0 is the bottom edge itself
                acc_l_d = AW'(xdl_q) * AW'(dy_c) + AW'(dxl_c);
                acc_r_d = AW'(xdr_q) * AW'(dy_c) + AW'(dxr_c);
                if (bad_c) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    po_d       = 1'b1;
                    xo_d       = xdl_q;
                    yo_d       = yd_q;
                    row_l_d    = xdl_q;
                    row_r_d    = xdr_q;
                    odd_d      = 1'b0;
                    row_load_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!row_load_q) begin
                    if (xfer_c) begin
                        if (!eor_c) begin
                            xo_d = rev_c ? (xo - W'(1)) : (xo + W'(1));
                        end else begin
                            po_d = 1'b0;
                            if (last_row_c) begin
                                done_d = 1'b1;
                            end else begin
                                row_load_d = 1'b1;
                                yo_d       = yo + W'(1);
                                odd_d      = ~odd_q;
                            end
                        end
                    end
                end else begin
                    // Row setup bubble: odd_q already holds this row's parity
                    acc_l_d = acc_l_q + AW'(dxl_q);
                    acc_r_d = acc_r_q + AW'(dxr_q);
                    if (row_ok_c) begin
                        po_d       = 1'b1;
                        row_load_d = 1'b0;
                        row_l_d    = W'(xl_c);
                        row_r_d    = W'(xr_c);
                        xo_d       = rev_c ? W'(xr_c) : W'(xl_c);
                    end else if (last_row_c) begin
                        done_d = 1'b1;
                    end else begin
                        yo_d  = yo + W'(1);
                        odd_d = ~odd_q;
                    end
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
                po_d   = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xul_q      <= '0;
            xur_q      <= '0;
            xdl_q      <= '0;
            xdr_q      <= '0;
            yu_q       <= '0;
            yd_q       <= '0;
            dy_q       <= '0;
            dxl_q      <= '0;
            dxr_q      <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            row_l_q    <= '0;
            row_r_q    <= '0;
            odd_q      <= 1'b0;
            row_load_q <= 1'b0;
            load_cnt_q <= 2'd0;
            busy       <= 1'b0;
            po         <= 1'b0;
            xo         <= '0;
            yo         <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            xul_q      <= xul_d;
            xur_q      <= xur_d;
            xdl_q      <= xdl_d;
            xdr_q      <= xdr_d;
            yu_q       <= yu_d;
            yd_q       <= yd_d;
            dy_q       <= dy_d;
            dxl_q      <= dxl_d;
            dxr_q      <= dxr_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
            row_l_q    <= row_l_d;
            row_r_q    <= row_r_d;
            odd_q      <= odd_d;
            row_load_q <= row_load_d;
            load_cnt_q <= load_cnt_d;
            busy       <= busy_d;
            po         <= po_d;
            xo         <= xo_d;
            yo         <= yo_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: doc/trapezoid_raster_stream.md
Name: trapezoid_raster_stream

Overview:
- Parametrised, fully synthesisable trapezoid scan-converter.
- Accepts four signed vertices of a horizontal-edged trapezoid and streams every covered integer pixel as (xo, yo) over a valid/ready interface.
- Supersedes the fixed 8-bit, delay-driven rasteriser: generic coordinate width, output backpressure, input validation, optional serpentine scan, and exact integer edge rounding.
- Sits between the shape-command decoder and the pixel write-back FIFO.

Parameters:
W, 8, coordinate width; all coordinates are signed two's complement.
SERPENTINE, 0, 0 = every row scanned left to right; 1 = rows with odd row index (y-yd) scanned right to left.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
nt  input  1  new-trapezoid strobe; coincides with vertex 1
xi  input  W  vertex x, signed
yi  input  W  vertex y, signed
po_ready  input  1  downstream accepts pixel when high with po
busy  output  1  command in progress
po  output  1  pixel valid
xo  output  W  pixel x, signed
yo  output  W  pixel y, signed
done  output  1  one-cycle pulse after the last pixel is accepted, or after rejection
err  output  1  one-cycle pulse, coincident with done, when the command is rejected

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. While reset is high, busy=po=done=err=0, xo=yo=0, and the FSM is in IDLE. Reset mid-command aborts it; no further pixels are emitted.
- Load sequence: cycle 0 is nt=1 in IDLE and captures (xul,yu). Cycles 1, 2 and 3 capture (xur,–), (xdl,yd) and (xdr,–); y on cycles 1 and 3 is ignored. nt is ignored while busy=1.
- busy: rises on the edge that samples nt and falls with the done pulse.
- FSM states: IDLE -> LOAD (3 cycles) -> SETUP (1 cycle) -> RUN -> DONE (1 cycle) -> IDLE.
- SETUP validation: reject if yd>yu, xdl>xdr or xul>xur. On rejection go to DONE with err=1 and emit no pixels.
- Setup arithmetic: compute dy=yu-yd and the edge deltas in W+1 bits. Edge accumulators are 2W+2 bits wide, so overflow is impossible.
- Row bounds, for k = 0..dy and y = yd+k:
  - xl(k) = ceil(xdl + (xul-xdl)*k/dy)
  - xr(k) = floor(xdr + (xur-xdr)*k/dy)
  - These use exact rational arithmetic with no accumulated rounding drift. If dy=0, only row yd is emitted, with xl=xdl and xr=xdr.
  - If xl(k)>xr(k), the row is empty and is skipped silently.
- Scan order: rows run from yd up to yu. Within a row, x runs xl..xr, reversed for odd k when SERPENTINE=1.
- First pixel: presented with po=1 no earlier than cycle 5 (cycle 0 = nt).
- Handshake:
  - A pixel transfers on a clk edge where po&&po_ready.
  - While po=1 and po_ready=0, xo and yo are held stable and po stays high.
  - Within a row, with po_ready held high, pixels issue one per cycle with no bubbles.
  - Between rows, po may drop for row-setup bubbles, at most 2 cycles per row.
- DONE: entered the cycle after the last pixel's transfer edge; done=1 for exactly one cycle, then busy=0. A new nt is accepted in the cycle after DONE.
- No wrap: coordinates never wrap. All emitted x, y lie within the input extremes.

Test Plan:
1. Slanted case, W=8, SERPENTINE=0, po_ready=1. Input: xul=2, yu=2, xur=3, xdl=0, yd=0, xdr=4. Required: exactly 10 pixels in order (0..4,0), (1..3,1), (2..3,2); one done pulse; err=0.
2. Negative coordinates. Input: xul=-3, yu=-1, xur=-1, xdl=-3, yd=-2, xdr=-1. Required: 6 pixels, x = -3..-1 on rows y=-2 and y=-1; first po at cycle 5.
3. Backpressure, using case 1 with po_ready toggling 1,0,0,1,… Required: same 10-pixel sequence; xo/yo are stable during every stall; no pixel is duplicated or dropped.
4. dy=0. Input: yd=yu=5, xdl=1, xdr=3. Required: pixels (1,5), (2,5), (3,5), then done.
5. Invalid command, xdl=4 > xdr=2. Required: no po; done=err=1 on the same single cycle at cycle 5; busy falls right after.
6. Abort and restart: assert reset during RUN of case 1 after 3 pixels. Required: all outputs return to 0 immediately. A fresh case 4 command afterwards produces a correct stream. With SERPENTINE=1, case 1 produces row 1 as x = 3, 2, 1.
